// File: rtl/measurement_window_counter.sv
// Gated measurement counter: counts qualified cycles over a programmable window
// and publishes each count on a valid/ready port. MEAS_SATURATE_EN selects saturating accumulation.
module measurement_window_counter #(
  parameter int COUNT_W  = 12,
  parameter int WINDOW_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                continuous_i,
  input  logic [WINDOW_W-1:0] window_len_i,
  input  logic                measurement_en_i,
  output logic [COUNT_W-1:0]  result_o,
  output logic                result_ovf_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic                overrun_o,
  output logic                busy_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [COUNT_W-1:0]  r_acc;
  logic                r_ovf;
  logic [WINDOW_W-1:0] r_remaining;
  logic [WINDOW_W-1:0] r_len;
  logic                r_cont;
  logic [COUNT_W-1:0]  r_result;
  logic                r_result_ovf;
  logic                r_result_valid;
  logic                r_overrun;

  logic                w_acc_full;
  logic [COUNT_W-1:0]  w_acc_inc;
  logic [COUNT_W-1:0]  w_acc_sum;
  logic                w_ovf_sum;
  logic                w_final;
  logic [WINDOW_W-1:0] w_len_eff;

  assign w_acc_full = &r_acc;

`ifdef MEAS_SATURATE_EN
  assign w_acc_inc = w_acc_full ? r_acc : r_acc + 1'b1;
`else
  assign w_acc_inc = r_acc + 1'b1;
`endif

  // Sum and flag including the current cycle's sample, used both for
  // ordinary accumulation and for the published value on the final cycle.
  assign w_acc_sum = measurement_en_i ? w_acc_inc : r_acc;
  assign w_ovf_sum = r_ovf | (measurement_en_i & w_acc_full);
  assign w_final   = (r_state == ST_RUN) && (r_remaining == WINDOW_W'(1));
  assign w_len_eff = (window_len_i == '0) ? WINDOW_W'(1) : window_len_i;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_state_next = ST_RUN;
      ST_RUN:  if (stop_i || (w_final && !r_cont)) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state        <= ST_IDLE;
      r_acc          <= '0;
      r_ovf          <= 1'b0;
      r_remaining    <= '0;
      r_len          <= '0;
      r_cont         <= 1'b0;
      r_result       <= '0;
      r_result_ovf   <= 1'b0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Acceptance clears valid; a result landing on the same edge overrides below.
      if (result_ready_i) r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_len       <= w_len_eff;
            r_cont      <= continuous_i;
            r_remaining <= w_len_eff;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_overrun   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_final) begin
            r_result       <= w_acc_sum;
            r_result_ovf   <= w_ovf_sum;
            r_result_valid <= 1'b1;
            if (r_result_valid && !result_ready_i) r_overrun <= 1'b1;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= (r_cont && !stop_i) ? r_len : '0;
          end else if (stop_i) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= '0;
          end else begin
            r_acc       <= w_acc_sum;
            r_ovf       <= w_ovf_sum;
            r_remaining <= r_remaining - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o       = r_result;
  assign result_ovf_o   = r_result_ovf;
  assign result_valid_o = r_result_valid;
  assign overrun_o      = r_overrun;
  assign busy_o         = (r_state == ST_RUN);

endmodule

// File: tb/tb_measurement_window_counter.sv
// Self-checking bench for measurement_window_counter: a default-width and a 4-bit
// instance share stimulus; expected window counts are queued as stimulus is driven.
module tb_measurement_window_counter;
  localparam int CW = 12;
  localparam int WW = 16;
  localparam int NW = 4;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          continuous_i = 1'b0;
  logic [WW-1:0] window_len_i = '0;
  logic          measurement_en_i = 1'b0;
  logic          result_ready_i = 1'b0;

  logic [CW-1:0] result_o;
  logic          result_ovf_o, result_valid_o, overrun_o, busy_o;
  logic [NW-1:0] n_result_o;
  logic          n_result_ovf_o, n_result_valid_o, n_overrun_o, n_busy_o;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          ovf;
    logic [NW-1:0] ncnt;
    logic          novf;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_r;

  always #5 clk_i = ~clk_i;

  measurement_window_counter #(.COUNT_W(CW), .WINDOW_W(WW)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .window_len_i(window_len_i),
    .measurement_en_i(measurement_en_i), .result_o(result_o),
    .result_ovf_o(result_ovf_o), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  measurement_window_counter #(.COUNT_W(NW), .WINDOW_W(WW)) u_dut_narrow (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .window_len_i(window_len_i),
    .measurement_en_i(measurement_en_i), .result_o(n_result_o),
    .result_ovf_o(n_result_ovf_o), .result_valid_o(n_result_valid_o),
    .result_ready_i(result_ready_i), .overrun_o(n_overrun_o), .busy_o(n_busy_o)
  );

  function automatic exp_t make_exp(input int n);
    exp_t e;
    e.ovf  = (n > 4095);
    e.novf = (n > 15);
`ifdef MEAS_SATURATE_EN
    e.cnt  = e.ovf ? 12'hFFF : CW'(n);
    e.ncnt = e.novf ? 4'hF : NW'(n);
`else
    e.cnt  = CW'(n % 4096);
    e.ncnt = NW'(n % 16);
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic begin_window(input int len, input bit cont);
    window_len_i = WW'(len);
    continuous_i = cont;
    start_i      = 1'b1;
    model_cnt    = 0;
    tick();
    start_i      = 1'b0;
  endtask

  // Drives one window cycle; on the last cycle of a window the expected result is queued.
  task automatic drive_cycle(input bit en, input bit last);
    measurement_en_i = en;
    if (en) model_cnt++;
    if (last) begin
      sb_q.push_back(make_exp(model_cnt));
      model_cnt = 0;
    end
    tick();
    measurement_en_i = 1'b0;
  endtask

  task automatic consume();
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({result_o, result_ovf_o, result_valid_o, overrun_o, busy_o,
         n_result_o, n_result_ovf_o, n_result_valid_o, n_overrun_o, n_busy_o} !== '0) begin
      $display("FAIL reset_initial: outputs=%h required all zero",
               {result_o, result_ovf_o, result_valid_o, overrun_o, busy_o});
      errors++;
    end
    begin_window(3, 1'b0);
    for (int j = 1; j <= 3; j++) drive_cycle(1'b1, j == 3);
    exp_r = sb_q.pop_front();
    checks++;
    if ({result_valid_o, result_o, result_ovf_o, n_result_o, n_result_ovf_o} !==
        {1'b1, exp_r.cnt, exp_r.ovf, exp_r.ncnt, exp_r.novf}) begin
      $display("FAIL reset_pre_pub: valid=%0b result=%0d required valid=1 result=%0d",
               result_valid_o, result_o, exp_r.cnt);
      errors++;
    end
    $display("txn reset_pre: result=%0d ovf=%0b", result_o, result_ovf_o);
    begin_window(10, 1'b0);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({result_o, result_ovf_o, result_valid_o, overrun_o, busy_o,
         n_result_o, n_result_ovf_o, n_result_valid_o, n_overrun_o, n_busy_o} !== '0) begin
      $display("FAIL reset_midwindow: result=%0d valid=%0b busy=%0b required all zero",
               result_o, result_valid_o, busy_o);
      errors++;
    end
    tick();
    rst_n_i = 1'b1;
    begin_window(2, 1'b0);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1);
    exp_r = sb_q.pop_front();
    checks++;
    if ({result_valid_o, busy_o, result_o, result_ovf_o, n_result_o, n_result_ovf_o} !==
        {1'b1, 1'b0, exp_r.cnt, exp_r.ovf, exp_r.ncnt, exp_r.novf}) begin
      $display("FAIL reset_post_pub: valid=%0b busy=%0b result=%0d required 1/0/%0d",
               result_valid_o, busy_o, result_o, exp_r.cnt);
      errors++;
    end
    $display("txn reset_post: result=%0d ovf=%0b", result_o, result_ovf_o);
    consume();
  endtask

  task automatic test_oneshot();
    begin_window(10, 1'b0);
    checks++;
    if (busy_o !== 1'b1) begin
      $display("FAIL oneshot_busy: busy=%0b required 1", busy_o);
      errors++;
    end
    for (int j = 1; j <= 9; j++) drive_cycle(j >= 3 && j <= 6, 1'b0);
    checks++;
    if (result_valid_o !== 1'b0) begin
      $display("FAIL oneshot_early: valid=%0b required 0", result_valid_o);
      errors++;
    end
    drive_cycle(1'b0, 1'b1);
    exp_r = sb_q.pop_front();
    checks++;
    if ({result_valid_o, busy_o, result_o, result_ovf_o, n_result_o, n_result_ovf_o} !==
        {1'b1, 1'b0, exp_r.cnt, exp_r.ovf, exp_r.ncnt, exp_r.novf}) begin
      $display("FAIL oneshot_pub: valid=%0b busy=%0b result=%0d ovf=%0b required 1/0/%0d/%0b",
               result_valid_o, busy_o, result_o, result_ovf_o, exp_r.cnt, exp_r.ovf);
      errors++;
    end
    $display("txn oneshot: result=%0d ovf=%0b", result_o, result_ovf_o);
    for (int j = 0; j < 3; j++) tick();
    checks++;
    if ({result_valid_o, result_o} !== {1'b1, exp_r.cnt}) begin
      $display("FAIL oneshot_hold: valid=%0b result=%0d required 1/%0d",
               result_valid_o, result_o, exp_r.cnt);
      errors++;
    end
    consume();
    checks++;
    if (result_valid_o !== 1'b0) begin
      $display("FAIL oneshot_accept: valid=%0b required 0", result_valid_o);
      errors++;
    end
  endtask

  task automatic test_overflow();
    begin_window(20, 1'b0);
    for (int j = 1; j <= 20; j++) drive_cycle(1'b1, j == 20);
    exp_r = sb_q.pop_front();
    checks++;
    if ({result_o, result_ovf_o, n_result_valid_o, n_result_o, n_result_ovf_o} !==
        {exp_r.cnt, exp_r.ovf, 1'b1, exp_r.ncnt, exp_r.novf}) begin
      $display("FAIL overflow_pub: result=%0d ovf=%0b nresult=%0d novf=%0b required %0d/%0b/%0d/%0b",
               result_o, result_ovf_o, n_result_o, n_result_ovf_o,
               exp_r.cnt, exp_r.ovf, exp_r.ncnt, exp_r.novf);
      errors++;
    end
    $display("txn overflow: result=%0d ovf=%0b narrow=%0d novf=%0b",
             result_o, result_ovf_o, n_result_o, n_result_ovf_o);
    consume();
  endtask

  task automatic test_back_to_back();
    begin_window(5, 1'b1);
    for (int j = 1; j <= 10; j++) begin
      drive_cycle(j % 2 == 1, j % 5 == 0);
      if (j % 5 == 0) begin
        exp_r = sb_q.pop_front();
        checks++;
        if ({result_valid_o, busy_o, overrun_o, result_o, n_result_o} !==
            {1'b1, 1'b1, (j == 10), exp_r.cnt, exp_r.ncnt}) begin
          $display("FAIL cont_pub_%0d: valid=%0b busy=%0b overrun=%0b result=%0d required 1/1/%0b/%0d",
                   j, result_valid_o, busy_o, overrun_o, result_o, (j == 10), exp_r.cnt);
          errors++;
        end
        $display("txn cont_window_%0d: result=%0d overrun=%0b", j / 5, result_o, overrun_o);
      end
    end
    stop_i = 1'b1;
    drive_cycle(1'b1, 1'b0);
    stop_i = 1'b0;
    checks++;
    if ({busy_o, result_valid_o, result_o, overrun_o} !== {1'b0, 1'b1, exp_r.cnt, 1'b1}) begin
      $display("FAIL cont_stop: busy=%0b valid=%0b result=%0d overrun=%0b required 0/1/%0d/1",
               busy_o, result_valid_o, result_o, overrun_o, exp_r.cnt);
      errors++;
    end
    consume();
    begin_window(5, 1'b1);
    checks++;
    if (overrun_o !== 1'b0) begin
      $display("FAIL cont_overrun_clear: overrun=%0b required 0", overrun_o);
      errors++;
    end
    for (int j = 1; j <= 10; j++) begin
      if (j == 10) result_ready_i = 1'b1;
      drive_cycle(j % 2 == 1, j % 5 == 0);
      result_ready_i = 1'b0;
      if (j % 5 == 0) begin
        exp_r = sb_q.pop_front();
        checks++;
        if ({result_valid_o, overrun_o, result_o, n_result_o, n_overrun_o} !==
            {1'b1, 1'b0, exp_r.cnt, exp_r.ncnt, 1'b0}) begin
          $display("FAIL collide_pub_%0d: valid=%0b overrun=%0b result=%0d required 1/0/%0d",
                   j, result_valid_o, overrun_o, result_o, exp_r.cnt);
          errors++;
        end
        $display("txn collide_window_%0d: result=%0d overrun=%0b", j / 5, result_o, overrun_o);
      end
    end
    stop_i = 1'b1;
    drive_cycle(1'b0, 1'b0);
    stop_i = 1'b0;
    consume();
  endtask

  task automatic test_abort();
    begin_window(8, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      if (j == 4) stop_i = 1'b1;
      drive_cycle(1'b1, 1'b0);
    end
    stop_i = 1'b0;
    checks++;
    if ({busy_o, result_valid_o, n_result_valid_o} !== 3'b000) begin
      $display("FAIL abort_mid: busy=%0b valid=%0b required 0/0", busy_o, result_valid_o);
      errors++;
    end
    tick();
    tick();
    checks++;
    if ({busy_o, result_valid_o} !== 2'b00) begin
      $display("FAIL abort_quiet: busy=%0b valid=%0b required 0/0", busy_o, result_valid_o);
      errors++;
    end
    begin_window(8, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      if (j == 8) stop_i = 1'b1;
      drive_cycle(1'b1, j == 8);
    end
    stop_i = 1'b0;
    exp_r = sb_q.pop_front();
    checks++;
    if ({result_valid_o, busy_o, result_o, result_ovf_o, n_result_o} !==
        {1'b1, 1'b0, exp_r.cnt, exp_r.ovf, exp_r.ncnt}) begin
      $display("FAIL abort_final: valid=%0b busy=%0b result=%0d required 1/0/%0d",
               result_valid_o, busy_o, result_o, exp_r.cnt);
      errors++;
    end
    $display("txn abort_final: result=%0d ovf=%0b", result_o, result_ovf_o);
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      $display("FAIL abort_idle: busy=%0b required 0", busy_o);
      errors++;
    end
    consume();
  endtask

  task automatic test_zero_length();
    begin_window(0, 1'b0);
    drive_cycle(1'b1, 1'b1);
    exp_r = sb_q.pop_front();
    checks++;
    if ({result_valid_o, busy_o, result_o, result_ovf_o, n_result_o} !==
        {1'b1, 1'b0, exp_r.cnt, exp_r.ovf, exp_r.ncnt}) begin
      $display("FAIL zero_len: valid=%0b busy=%0b result=%0d required 1/0/%0d",
               result_valid_o, busy_o, result_o, exp_r.cnt);
      errors++;
    end
    $display("txn zero_len: result=%0d ovf=%0b", result_o, result_ovf_o);
    consume();
  endtask

  initial begin
    rst_n_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
    test_reset();
    test_oneshot();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_zero_length();
    checks++;
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard_drain: pending=%0d required 0", sb_q.size());
      errors++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
